// File: rtl/alu_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : alu_decode_stage
// Purpose  : RV32 OP/OP-IMM decode into ALU control and operands, held in a
//            single-entry valid/ready pipeline register.
//            Optional LUI/AUIPC decode when ALU_DECODE_UPPER_IMM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] src1,
    output logic [31:0] src2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal
);

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_SLL  = 4'b0100;
    localparam logic [3:0] c_ALU_SLT  = 4'b0101;
    localparam logic [3:0] c_ALU_SRL  = 4'b0110;
    localparam logic [3:0] c_ALU_SLTU = 4'b0111;
    localparam logic [3:0] c_ALU_XOR  = 4'b1000;
    localparam logic [3:0] c_ALU_SRA  = 4'b1001;

    localparam logic [6:0] c_OPC_OP     = 7'b0110011;
    localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
`ifdef ALU_DECODE_UPPER_IMM_EN
    localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
`endif

    localparam logic [6:0] c_F7_BASE = 7'b0000000;
    localparam logic [6:0] c_F7_ALT  = 7'b0100000;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [3:0]  w_alu_ctrl;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic        w_illegal;
    logic        w_reg_write;
    logic        w_load;
    logic        w_unused;

    logic        r_out_valid;
    logic [3:0]  r_alu_ctrl;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_illegal;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_rd     = instr[11:7];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    // Register specifier rs1 is resolved upstream; pc only matters for AUIPC.
    assign w_unused = ^{instr[19:15], pc};

    // alt selects SUB for funct3=000 and SRA for funct3=101.
    function automatic logic [3:0] f3_to_ctrl(input logic [2:0] f3, input logic alt);
        logic [3:0] v;
        case (f3)
            3'b000:  v = alt ? c_ALU_SUB : c_ALU_ADD;
            3'b001:  v = c_ALU_SLL;
            3'b010:  v = c_ALU_SLT;
            3'b011:  v = c_ALU_SLTU;
            3'b100:  v = c_ALU_XOR;
            3'b101:  v = alt ? c_ALU_SRA : c_ALU_SRL;
            3'b110:  v = c_ALU_OR;
            default: v = c_ALU_AND;
        endcase
        return v;
    endfunction

    always_comb begin
        w_alu_ctrl = c_ALU_ADD;
        w_src1     = 32'd0;
        w_src2     = 32'd0;
        w_illegal  = 1'b1;
        case (w_opcode)
            c_OPC_OP: begin
                if ((w_funct7 == c_F7_BASE) ||
                    ((w_funct7 == c_F7_ALT) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101)))) begin
                    w_illegal  = 1'b0;
                    w_alu_ctrl = f3_to_ctrl(w_funct3, w_funct7 == c_F7_ALT);
                    w_src1     = rs1_data;
                    w_src2     = rs2_data;
                end
            end
            c_OPC_OP_IMM: begin
                if (!(((w_funct3 == 3'b001) && (w_funct7 != c_F7_BASE)) ||
                      ((w_funct3 == 3'b101) && (w_funct7 != c_F7_BASE) && (w_funct7 != c_F7_ALT)))) begin
                    w_illegal  = 1'b0;
                    w_alu_ctrl = f3_to_ctrl(w_funct3, (w_funct3 == 3'b101) && (w_funct7 == c_F7_ALT));
                    w_src1     = rs1_data;
                    w_src2     = w_imm_i;
                end
            end
`ifdef ALU_DECODE_UPPER_IMM_EN
            c_OPC_LUI: begin
                w_illegal = 1'b0;
                w_src2    = {instr[31:12], 12'd0};
            end
            c_OPC_AUIPC: begin
                w_illegal = 1'b0;
                w_src1    = pc;
                w_src2    = {instr[31:12], 12'd0};
            end
`endif
            default: ;
        endcase
    end

    assign w_reg_write = !w_illegal && (w_rd != 5'd0);
    assign in_ready    = !flush && (!r_out_valid || out_ready);
    assign w_load      = in_valid && in_ready;

    // Payload is left untouched on drain so the bus stays quiet between entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_alu_ctrl  <= c_ALU_ADD;
            r_src1      <= 32'd0;
            r_src2      <= 32'd0;
            r_rd        <= 5'd0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_alu_ctrl  <= w_alu_ctrl;
            r_src1      <= w_src1;
            r_src2      <= w_src2;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_illegal   <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign alu_ctrl  = r_alu_ctrl;
    assign src1      = r_src1;
    assign src2      = r_src2;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign illegal   = r_illegal;

endmodule
`default_nettype wire
